exu_muldiv: RTL and testbench
=============================

Name: exu_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EXU stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered operands, op and destination address from that register.
- Holds the pipeline with a stall while computing.
- Returns one result with its writeback address to the EXU result mux.

Parameters:
- XLEN, 32, operand/result width (equals CPU_WIDTH).
- RADDR_W, 5, register address width (equals REG_ADDR_WIDTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- md_valid_i  in  1  registered M-extension instruction valid (ID/EX enable AND decoded M-op)
- md_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- md_src1_i  in  XLEN  rs1 value
- md_src2_i  in  XLEN  rs2 value
- md_waddr_i  in  RADDR_W  destination register
- flush_i  in  1  branch_en | jump_en; aborts the operation in flight
- md_stall_o  out  1  hold IF/ID and ID/EX registers
- md_done_o  out  1  one-cycle result-valid pulse
- md_result_o  out  XLEN  result
- md_waddr_o  out  RADDR_W  destination register of the result

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- States: IDLE, CALC, DONE.
  - Reset: state IDLE, counter 0, all datapath regs 0.
  - Reset outputs: md_done_o=0, md_result_o=0, md_waddr_o=0, md_stall_o=0.
  - Reset mid-operation: state and datapath regs clear immediately (asynchronous); no done pulse is produced.
- IDLE:
  - If md_valid_i=1 and flush_i=0, the operation is captured.
  - Operands: absolute values for signed ops (MULH/DIV/REM both operands; MULHSU rs1 only); result sign flag stored.
  - Op and waddr are latched.
  - Normal path: counter=31, go to CALC.
  - Fast path, divide by zero (rs2=0): result = all-ones for DIV/DIVU, rs1 for REM/REMU; go directly to DONE.
  - Fast path, signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000, REM result 0; go directly to DONE.
- CALC:
  - One iteration per cycle: shift-add multiply (64-bit product) or restoring divide (quotient + remainder).
  - Counter decrements each cycle; at counter=0, apply sign fixup and go to DONE.
  - Sign fixup: negate product/quotient if the sign flag is set; the remainder takes the dividend's sign.
  - Select: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
- DONE:
  - md_done_o=1 for exactly one cycle, with md_result_o/md_waddr_o valid in that cycle; then IDLE.
  - No new accept in DONE. md_valid_i still shows the same instruction that cycle (the pipeline advances on this edge), so it must not be re-executed.
- md_result_o/md_waddr_o hold their last values after DONE.
- Latency, counting the accept edge as 0:
  - Normal path: done in cycle 33 (32 CALC cycles); instruction occupies EX for 34 cycles.
  - Fast path: done in cycle 1.
- md_stall_o = (state==IDLE & md_valid_i & ~flush_i) | (state==CALC). It is 0 in DONE.
- flush_i has priority in every state: go to IDLE, no done pulse, latched data discarded.
- md_valid_i while in CALC is ignored (the pipeline is stalled, so the input is the same instruction).

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL* ops use a single-cycle combinational 33x33 signed multiplier and go IDLE->DONE (done in cycle 1, stall for 1 cycle). Divides are unchanged.
- Undefined: all ops use the iterative path; no hardware multiplier is instantiated.

Decomposition:
- Shared package/defines:
  - MD_OP_* funct3 encodings.
  - MD_STATE_* encodings.
  - MD_ITER_CNT=32.
  - XLEN and register-address widths, reusing CPU_WIDTH and REG_ADDR_WIDTH.
- One natural sub-module, md_sign_fix: combinational operand abs/negate and result-sign logic, used at capture and at fixup.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB; md_done_o in cycle 33 after accept; md_stall_o high cycles 0..32, low on done.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF; MULH 0x80000000 * 0x80000000 -> 0x40000000.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both in 1 cycle; DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2; md_waddr_o matches the captured waddr.
- flush_i asserted in cycle 10 of a DIV -> no md_done_o, IDLE next cycle, stall drops; a following MUL accepts and completes correctly.
- rst_n asserted mid-CALC -> all outputs 0 immediately; after release, a new op accepts normally. Back-to-back MULs with md_valid_i held: exactly one done per instruction.

Source files
------------

// File: rtl/exu_muldiv_pkg.sv
// exu_muldiv_pkg: shared encodings, widths and helpers for the RV32M
// multiply/divide unit (exu_muldiv and md_sign_fix).
`timescale 1ns/1ps
package exu_muldiv_pkg;

  localparam int CPU_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int MD_ITER_CNT    = 32;
  localparam int MD_CNT_W       = $clog2(MD_ITER_CNT);

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_STATE_IDLE = 2'd0,
    MD_STATE_CALC = 2'd1,
    MD_STATE_DONE = 2'd2
  } md_state_e;

  // rs1 is interpreted as signed
  function automatic logic md_src1_signed(input md_op_e op);
    return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_REM);
  endfunction

  // rs2 is interpreted as signed
  function automatic logic md_src2_signed(input md_op_e op);
    return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  // Pick the architectural result out of the fixed-up datapath values
  function automatic logic [CPU_WIDTH-1:0] md_select(
    input md_op_e                  op,
    input logic [2*CPU_WIDTH-1:0]  prod,
    input logic [CPU_WIDTH-1:0]    quo,
    input logic [CPU_WIDTH-1:0]    rem
  );
    case (op)
      MD_OP_MUL:                     return prod[CPU_WIDTH-1:0];
      MD_OP_MULH, MD_OP_MULHSU,
      MD_OP_MULHU:                   return prod[2*CPU_WIDTH-1:CPU_WIDTH];
      MD_OP_DIV, MD_OP_DIVU:         return quo;
      default:                       return rem;
    endcase
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: conditional two's-complement negate. Used to take absolute
// values of operands at capture and to restore the sign of results at fixup.
`timescale 1ns/1ps
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  // Negate when the flag is set, pass through otherwise
  always_comb begin
    val_o = neg_i ? (~val_i + W'(1)) : val_i;
  end

endmodule

// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative RV32M multiply/divide unit for the EXU stage.
// Shift-add multiply and restoring divide on unsigned magnitudes, one
// iteration per cycle, with sign fixup on the last iteration.
// Optional macro MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle 33x33
// signed multiplier and complete in one cycle; divides stay iterative.
//
// Handshake: md_valid_i is sampled only in IDLE. While the unit computes,
// md_stall_o freezes the upstream registers so md_valid_i keeps presenting
// the same instruction; it is ignored in CALC and DONE. md_done_o pulses for
// one cycle with md_result_o/md_waddr_o valid, and those outputs hold until
// the next result. flush_i aborts in any state without a done pulse.
`timescale 1ns/1ps
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN    = CPU_WIDTH,
  parameter int RADDR_W = REG_ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               md_valid_i,
  input  logic [2:0]         md_op_i,
  input  logic [XLEN-1:0]    md_src1_i,
  input  logic [XLEN-1:0]    md_src2_i,
  input  logic [RADDR_W-1:0] md_waddr_i,
  input  logic               flush_i,
  output logic               md_stall_o,
  output logic               md_done_o,
  output logic [XLEN-1:0]    md_result_o,
  output logic [RADDR_W-1:0] md_waddr_o
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e             state_q;
  logic [MD_CNT_W-1:0]   cnt_q;
  md_op_e                op_q;
  logic [RADDR_W-1:0]    waddr_q;
  logic [XLEN-1:0]       hi_q, lo_q, b_q;
  logic                  res_neg_q, rem_neg_q;
  logic                  done_q;
  logic [XLEN-1:0]       result_q;
  logic [RADDR_W-1:0]    waddr_out_q;

  // Capture-side decode
  md_op_e          op_in;
  logic            neg1_in, neg2_in;
  logic [XLEN-1:0] abs1_in, abs2_in;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

  assign op_in   = md_op_e'(md_op_i);
  assign neg1_in = md_src1_signed(op_in) & md_src1_i[XLEN-1];
  assign neg2_in = md_src2_signed(op_in) & md_src2_i[XLEN-1];

  md_sign_fix #(.W(XLEN)) u_abs1 (.val_i(md_src1_i), .neg_i(neg1_in), .val_o(abs1_in));
  md_sign_fix #(.W(XLEN)) u_abs2 (.val_i(md_src2_i), .neg_i(neg2_in), .val_o(abs2_in));

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] fa, fb;
  logic [2*XLEN-1:0]    fast_prod;
  assign fa        = {md_src1_signed(op_in) & md_src1_i[XLEN-1], md_src1_i};
  assign fb        = {md_src2_signed(op_in) & md_src2_i[XLEN-1], md_src2_i};
  assign fast_prod = (2*XLEN)'(fa * fb);
`endif

  // Results that need no iteration: divide by zero, signed overflow, fast multiply
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (md_op_i[2] && (md_src2_i == '0)) begin
      fast_hit = 1'b1;
      fast_res = md_op_i[1] ? md_src1_i : '1;
    end else if (((op_in == MD_OP_DIV) || (op_in == MD_OP_REM)) &&
                 (md_src1_i == XMIN) && (md_src2_i == '1)) begin
      fast_hit = 1'b1;
      fast_res = md_op_i[1] ? '0 : XMIN;
`ifdef MULDIV_FAST_MUL_EN
    end else if (!md_op_i[2]) begin
      fast_hit = 1'b1;
      fast_res = md_select(op_in, fast_prod, '0, '0);
`endif
    end
  end

  // One iteration step: hi/lo hold {acc, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            div_ok;
  logic [XLEN-1:0] iter_hi, iter_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, calc_res;

  // Next hi/lo for the current op class
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_ok   = ~div_diff[XLEN];
    if (op_q[2]) begin
      iter_hi = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      iter_lo = {lo_q[XLEN-2:0], div_ok};
    end else begin
      iter_hi = mul_sum[XLEN:1];
      iter_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  md_sign_fix #(.W(2*XLEN)) u_fix_prod (.val_i({iter_hi, iter_lo}), .neg_i(res_neg_q), .val_o(prod_fix));
  md_sign_fix #(.W(XLEN))   u_fix_quo  (.val_i(iter_lo), .neg_i(res_neg_q), .val_o(quo_fix));
  md_sign_fix #(.W(XLEN))   u_fix_rem  (.val_i(iter_hi), .neg_i(rem_neg_q), .val_o(rem_fix));

  assign calc_res = md_select(op_q, prod_fix, quo_fix, rem_fix);

  // Control FSM with datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MD_STATE_IDLE;
      cnt_q       <= '0;
      op_q        <= MD_OP_MUL;
      waddr_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      res_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      waddr_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= MD_STATE_IDLE;
      end else begin
        case (state_q)
          MD_STATE_IDLE: begin
            if (md_valid_i) begin
              op_q      <= op_in;
              waddr_q   <= md_waddr_i;
              hi_q      <= '0;
              lo_q      <= abs1_in;
              b_q       <= abs2_in;
              res_neg_q <= neg1_in ^ neg2_in;
              rem_neg_q <= neg1_in;
              cnt_q     <= MD_CNT_W'(MD_ITER_CNT - 1);
              if (fast_hit) begin
                state_q     <= MD_STATE_DONE;
                done_q      <= 1'b1;
                result_q    <= fast_res;
                waddr_out_q <= md_waddr_i;
              end else begin
                state_q <= MD_STATE_CALC;
              end
            end
          end
          MD_STATE_CALC: begin
            hi_q <= iter_hi;
            lo_q <= iter_lo;
            if (cnt_q == '0) begin
              state_q     <= MD_STATE_DONE;
              done_q      <= 1'b1;
              result_q    <= calc_res;
              waddr_out_q <= waddr_q;
            end else begin
              cnt_q <= cnt_q - MD_CNT_W'(1);
            end
          end
          // md_valid_i still shows the finished instruction here: do not accept
          default: state_q <= MD_STATE_IDLE;
        endcase
      end
    end
  end

  assign md_stall_o  = ((state_q == MD_STATE_IDLE) & md_valid_i & ~flush_i) |
                       (state_q == MD_STATE_CALC);
  assign md_done_o   = done_q;
  assign md_result_o = result_q;
  assign md_waddr_o  = waddr_out_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv: directed + random bench for exu_muldiv with a result
// scoreboard, latency/stall checks, flush abort and async reset abort.
`timescale 1ns/1ps
module tb_exu_muldiv;
  import exu_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        md_valid_i = 1'b0;
  logic [2:0]  md_op_i = '0;
  logic [31:0] md_src1_i = '0;
  logic [31:0] md_src2_i = '0;
  logic [4:0]  md_waddr_i = '0;
  logic        flush_i = 1'b0;
  logic        md_stall_o, md_done_o;
  logic [31:0] md_result_o;
  logic [4:0]  md_waddr_o;

  exu_muldiv dut (
    .clk(clk), .rst_n(rst_n),
    .md_valid_i(md_valid_i), .md_op_i(md_op_i),
    .md_src1_i(md_src1_i), .md_src2_i(md_src2_i),
    .md_waddr_i(md_waddr_i), .flush_i(flush_i),
    .md_stall_o(md_stall_o), .md_done_o(md_done_o),
    .md_result_o(md_result_o), .md_waddr_o(md_waddr_o)
  );

  // ---------------- scoreboard ----------------
  logic [36:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference RV32M semantics from 64-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] qa, qb;
    logic [31:0] r;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'h0, a};       ub = {32'h0, b};
    qa = a; qb = b;
    r = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(qa / qb));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(qa % qb));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (md_done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(md_done_o), 64'(0));
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("result", 64'(md_result_o), 64'(e[31:0]));
        check("waddr", 64'(md_waddr_o), 64'(e[36:32]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one op, hold it until done, check latency and stall profile
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic [31:0] exp_res, input int exp_lat);
    int n;
    int stall_bad;
    @(negedge clk);
    md_valid_i = 1'b1; md_op_i = op; md_src1_i = a; md_src2_i = b; md_waddr_i = wa; flush_i = 1'b0;
    exp_q.push_back({wa, exp_res});
    #1;
    check("stall_accept", 64'(md_stall_o), 64'(1));
    n = 0;
    stall_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!md_done_o && !md_stall_o) stall_bad++;
    end while (!md_done_o && n < 200);
    check("latency", 64'(n), 64'(exp_lat));
    check("stall_busy", 64'(stall_bad), 64'(0));
    check("stall_done", 64'(md_stall_o), 64'(0));
  endtask

  // Drop valid for one cycle and confirm the unit is quiet
  task automatic idle_check(input string tag);
    @(negedge clk);
    md_valid_i = 1'b0;
    #1;
    check({tag, "_stall"}, 64'(md_stall_o), 64'(0));
    check({tag, "_done"}, 64'(md_done_o), 64'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    check("rst_done", 64'(md_done_o), 64'(0));
    check("rst_result", 64'(md_result_o), 64'(0));
    check("rst_waddr", 64'(md_waddr_o), 64'(0));
    check("rst_stall", 64'(md_stall_o), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, MUL_LAT);
    idle_check("post_mul");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, MUL_LAT);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFF, MUL_LAT);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, MUL_LAT);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0, 1);
    run_op(3'd5, 32'h1234, 32'h0, 5'd9, 32'hFFFF_FFFF, 1);
    run_op(3'd7, 32'h1234, 32'h0, 5'd10, 32'h1234, 1);
    idle_check("post_fast");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD, 33);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF, 33);
    run_op(3'd5, 32'd100, 32'd7, 5'd13, 32'd14, 33);
    run_op(3'd7, 32'd100, 32'd7, 5'd14, 32'd2, 33);
    idle_check("post_div");

    // Flush in cycle 10 of a DIV: no result, back to IDLE
    @(negedge clk);
    md_valid_i = 1'b1; md_op_i = 3'd4; md_src1_i = 32'd5000; md_src2_i = 32'd3; md_waddr_i = 5'd15;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; md_valid_i = 1'b0;
    #1;
    check("flush_stall", 64'(md_stall_o), 64'(0));
    check("flush_done", 64'(md_done_o), 64'(0));
    check("flush_state", 64'(dut.state_q), 64'(MD_STATE_IDLE));
    repeat (40) @(negedge clk);
    run_op(3'd0, 32'h0001_0003, 32'h0000_0105, 5'd16, 32'h0105_030F, MUL_LAT);
    idle_check("post_flush");

    // Asynchronous reset mid-CALC
    @(negedge clk);
    md_valid_i = 1'b1; md_op_i = 3'd5; md_src1_i = 32'd1000; md_src2_i = 32'd3; md_waddr_i = 5'd17;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; md_valid_i = 1'b0;
    #1;
    check("arst_done", 64'(md_done_o), 64'(0));
    check("arst_result", 64'(md_result_o), 64'(0));
    check("arst_waddr", 64'(md_waddr_o), 64'(0));
    check("arst_stall", 64'(md_stall_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op(3'd5, 32'd1000, 32'd3, 5'd18, 32'd333, 33);

    // Back-to-back MULs with valid held: one done per instruction
    run_op(3'd0, 32'd12, 32'd12, 5'd19, 32'd144, MUL_LAT);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'd1, MUL_LAT);
    idle_check("post_b2b");

    // Random ops against the reference model
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      run_op(op, a, b, 5'($urandom_range(1, 31)), ref_md(op, a, b), ref_lat(op, a, b));
    end
    idle_check("end");
    repeat (5) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
